// File: rtl/dmem_arbiter_pkg.sv
// Shared sizing defaults and helpers for the core-to-data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned CORES_MAX      = 8;

    // Index width for n requesters; a single core still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after the pointer.
module rr_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  eligible,
    input  logic          advance,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] ptr;
    int unsigned   scan_idx;

    // Rotating priority scan starting from ptr.
    always_comb begin
        grant_idx = ptr;
        any       = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = (32'(ptr) + k) % N;
            if (!any && eligible[IW'(scan_idx)]) begin
                grant_idx = IW'(scan_idx);
                any       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= IW'((32'(grant_idx) + 32'd1) % N);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises per-core load/store requests onto a single-port data memory:
// one cycle to arbitrate, one cycle to access, ack and read data the cycle after.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned CORES      = 4,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CORES-1:0]            req,
    input  logic [CORES-1:0]            we,
    input  logic [CORES*ADDR_WIDTH-1:0] addr,
    input  logic [CORES*DATA_WIDTH-1:0] wdata,
    output logic [CORES*DATA_WIDTH-1:0] rdata,
    output logic [CORES-1:0]            ack,
    output logic [CORES-1:0]            stall,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic                        mem_we,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic [31:0]                 conflicts
);

    localparam int unsigned IW = idx_width(CORES);

    logic                  cmd_valid;
    logic                  cmd_we;
    logic [IW-1:0]         cmd_idx;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic [CORES-1:0]      inflight;
    logic [CORES-1:0]      eligible;
    logic [IW-1:0]         grant_idx;
    logic                  grant_any;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Winner's request fields and the mask of the core currently in the access stage.
    always_comb begin
        inflight  = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < CORES; i++) begin
            if (cmd_valid && (cmd_idx == IW'(i))) begin
                inflight[i] = 1'b1;
            end
            if (grant_idx == IW'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A core in flight or in its ack cycle is still holding its old request.
    assign eligible = req & ~inflight & ~ack;

    rr_arbiter #(
        .N  (CORES),
        .IW (IW)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .eligible  (eligible),
        .advance   (1'b1),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Arbitration stage: capture the winner's command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_idx   <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            cmd_valid <= grant_any;
            if (grant_any) begin
                cmd_we    <= sel_we;
                cmd_idx   <= grant_idx;
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
            end
        end
    end

    // Access stage completion: ack pulse, read data capture, contention count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack       <= '0;
            rdata     <= '0;
            conflicts <= '0;
        end else begin
            for (int i = 0; i < CORES; i++) begin
                ack[i] <= cmd_valid && (cmd_idx == IW'(i));
                if (cmd_valid && !cmd_we && (cmd_idx == IW'(i))) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                end
            end
            if (($countones(eligible) >= 2) && (conflicts != 32'hFFFF_FFFF)) begin
                conflicts <= conflicts + 32'd1;
            end
        end
    end

    // Address and data hold their last values when idle; the strobe drops with reset.
    assign mem_we    = cmd_valid & cmd_we;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign stall     = req & ~ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int NC = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int QD = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     req = '0;
    logic [NC-1:0]     we = '0;
    logic [NC*AW-1:0]  addr = '0;
    logic [NC*DW-1:0]  wdata = '0;
    logic [NC*DW-1:0]  rdata;
    logic [NC-1:0]     ack;
    logic [NC-1:0]     stall;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic [31:0]       conflicts;

    dmem_arbiter #(.CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .stall(stall), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    // Environment memory, with a poke port for preloading.
    logic [DW-1:0] mem [0:1023];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [DW-1:0] poke_d = '0;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: memory image, rr pointer, transaction ids, expected-response FIFO.
    logic [DW-1:0] rmem [0:1023];
    int            req_id [NC];
    int            gnt_id [NC];
    int            mptr = 0;
    int            mconf = 0;
    int            q_core [QD];
    logic          q_we [QD];
    logic [DW-1:0] q_data [QD];
    int            q_due [QD];
    int            head = 0;
    int            tail = 0;
    int            m_n, m_w, m_c, m_a;

    initial for (int i = 0; i < NC; i++) begin req_id[i] = 0; gnt_id[i] = 0; end

    // Model: serve outstanding requests one per cycle in rotating order.
    always @(negedge clk) begin
        if (reset) begin
            mptr  = 0;
            mconf = 0;
        end else begin
            if (poke_en) rmem[poke_a] = poke_d;
            m_n = 0;
            m_w = -1;
            for (int k = 0; k < NC; k++) begin
                m_c = (mptr + k) % NC;
                if (req[m_c] && (req_id[m_c] != gnt_id[m_c])) begin
                    m_n++;
                    if (m_w < 0) m_w = m_c;
                end
            end
            if (m_n >= 2) mconf++;
            if (m_w >= 0) begin
                gnt_id[m_w] = req_id[m_w];
                mptr = (m_w + 1) % NC;
                m_a = int'(addr[m_w*AW +: AW]);
                q_core[tail % QD] = m_w;
                q_we[tail % QD]   = we[m_w];
                q_due[tail % QD]  = cyc + 2;
                if (we[m_w]) begin
                    q_data[tail % QD] = wdata[m_w*DW +: DW];
                    rmem[m_a] = wdata[m_w*DW +: DW];
                end else begin
                    q_data[tail % QD] = rmem[m_a];
                end
                tail++;
            end
        end
    end

    // Monitor: compare each ack against the scoreboard head.
    logic [DW-1:0] exp_rd [NC];
    int            ack_cnt [NC];
    logic [NC*DW-1:0] exp_vec;
    initial for (int i = 0; i < NC; i++) begin exp_rd[i] = '0; ack_cnt[i] = 0; end

    always @(negedge clk) begin
        if (reset) begin
            head = tail;
            for (int i = 0; i < NC; i++) exp_rd[i] = '0;
        end else begin
            check("stall", 128'(stall), 128'(req & ~ack));
            for (int i = 0; i < NC; i++) begin
                if (ack[i]) begin
                    if (head == tail) begin
                        check("ack_unexpected", 128'(ack), 128'(0));
                    end else begin
                        check("ack_core", 128'(i), 128'(q_core[head % QD]));
                        check("ack_cycle", 128'(cyc), 128'(q_due[head % QD]));
                        if (!q_we[head % QD]) exp_rd[i] = q_data[head % QD];
                        for (int j = 0; j < NC; j++) exp_vec[j*DW +: DW] = exp_rd[j];
                        check("rdata", 128'(rdata), 128'(exp_vec));
                        head++;
                        ack_cnt[i]++;
                    end
                end
            end
            if ((head != tail) && (q_due[head % QD] < cyc)) begin
                check("ack_missing", 128'(q_due[head % QD]), 128'(cyc));
                head++;
            end
        end
    end

    // Driver helpers: inputs change 1 time unit after the rising edge.
    logic [NC-1:0] seen = '0;

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (seen[i]) req[i] = 1'b0;
            seen[i] = ack[i];
        end
    endtask

    task automatic issue(input int i, input logic w, input int a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        we[i]  = w;
        addr[i*AW +: AW]  = AW'(a);
        wdata[i*DW +: DW] = d;
        req_id[i]++;
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        poke_a  = AW'(a);
        poke_d  = d;
        poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (((req != '0) || (head != tail)) && (n < budget)) begin
            tick();
            n++;
        end
        total++;
        if ((req != '0) || (head != tail)) begin
            bad++;
            $display("FAIL drain_timeout: req=%0h pending=%0d after %0d cycles", req, tail - head, n);
        end
    endtask

    task automatic do_reset();
        req = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        seen = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int base [NC];
    int got;

    initial begin
        tick();
        check("reset_ack", 128'(ack), 128'(0));
        check("reset_rdata", 128'(rdata), 128'(0));
        check("reset_conflicts", 128'(conflicts), 128'(0));
        check("reset_mem_we", 128'(mem_we), 128'(0));
        reset = 1'b0;
        for (int a = 0; a < 16; a++) poke(a, $urandom);

        // Single uncontended read: latency and stall window.
        poke(5, 32'd7);
        issue(2, 1'b0, 5, '0);
        #1 check("t1_stall_c0", 128'(stall[2]), 128'(1));
        tick();
        check("t1_mem_addr_c1", 128'(mem_addr), 128'(5));
        check("t1_stall_c1", 128'(stall[2]), 128'(1));
        tick();
        check("t1_ack_c2", 128'(ack), 128'(4'b0100));
        check("t1_rdata2", 128'(rdata[2*DW +: DW]), 128'(7));
        wait_idle(20);

        // Four simultaneous reads from reset: served 0,1,2,3 with three contended edges.
        do_reset();
        for (int a = 0; a < 4; a++) poke(a, 32'(a + 1));
        for (int i = 0; i < NC; i++) issue(i, 1'b0, i, '0);
        wait_idle(30);
        check("t2_conflicts", 128'(conflicts), 128'(3));
        for (int i = 0; i < NC; i++) check("t2_rdata", 128'(rdata[i*DW +: DW]), 128'(i + 1));

        // Same-cycle write (core 0) and read (core 1) of one address.
        do_reset();
        poke(0, 32'h55);
        issue(0, 1'b1, 0, 32'd8);
        issue(1, 1'b0, 0, '0);
        wait_idle(20);
        check("t4_rdata1", 128'(rdata[1*DW +: DW]), 128'(8));

        // Saturated fairness window.
        do_reset();
        for (int i = 0; i < NC; i++) base[i] = ack_cnt[i];
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NC; i++)
                if (!req[i]) issue(i, 1'b0, $urandom_range(0, 15), '0);
            tick();
        end
        for (int i = 0; i < NC; i++) begin
            got = ack_cnt[i] - base[i];
            check("t3_fair", 128'((got >= 9) && (got <= 11)), 128'(1));
        end
        wait_idle(30);

        // Random mixed traffic over a small hot address set.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NC; i++)
                if (!req[i] && ($urandom_range(0, 99) < 40))
                    issue(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
            tick();
        end
        wait_idle(40);
        check("rand_conflicts", 128'(conflicts), 128'(mconf));

        // Reset during the access cycle of a write.
        do_reset();
        poke(4, 32'd5);
        issue(0, 1'b1, 4, 32'd9);
        tick();
        check("t5_mem_we_access", 128'(mem_we), 128'(1));
        check("t5_mem_addr_access", 128'(mem_addr), 128'(4));
        reset = 1'b1;
        #1;
        check("t5_mem_we_async", 128'(mem_we), 128'(0));
        check("t5_ack", 128'(ack), 128'(0));
        check("t5_rdata", 128'(rdata), 128'(0));
        check("t5_conflicts", 128'(conflicts), 128'(0));
        req = '0;
        tick();
        tick();
        check("t5_mem4", 128'(mem[4]), 128'(5));
        reset = 1'b0;
        tick();
        check("t5_no_ack", 128'(ack), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
